// File: rtl/tan_cordic_ctrl.sv
// Control FSM for the decimal-CORDIC tangent datapath: latches one angle request,
// sequences the datapath strobes and returns the outcome over a valid/ready handshake.
module tan_cordic_ctrl #(
  parameter int unsigned LOOP_TIMEOUT = 64,
  parameter int unsigned MAX_ROT      = 96,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [31:0] i_req_angle,
  output logic        o_busy,
  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic        o_res_error,
  output logic [31:0] o_dp_angle,
  output logic        o_dp_start,
  output logic        o_dp_start_loop,
  output logic        o_dp_tp_we,
  output logic        o_dp_y_we,
  output logic        o_dp_x_we,
  output logic        o_dp_angle_we,
  output logic        o_dp_verify,
  output logic        o_dp_mul_sel,
  output logic        o_dp_add_sel,
  output logic        o_dp_add_sub,
  input  logic        i_dp_loop_done,
  input  logic        i_dp_angle_gt,
  input  logic        i_dp_done
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StInit   = 4'd1;
  localparam logic [3:0] StLstart = 4'd2;
  localparam logic [3:0] StLwait  = 4'd3;
  localparam logic [3:0] StCheck  = 4'd4;
  localparam logic [3:0] StTp     = 4'd5;
  localparam logic [3:0] StYupd   = 4'd6;
  localparam logic [3:0] StXupd   = 4'd7;
  localparam logic [3:0] StVerify = 4'd8;
  localparam logic [3:0] StSettle = 4'd9;
  localparam logic [3:0] StOut    = 4'd10;
  localparam logic [3:0] StErr    = 4'd11;

  localparam logic [CNT_W-1:0] TmoLast = CNT_W'(LOOP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RotMax  = CNT_W'(MAX_ROT);
  localparam logic [CNT_W-1:0] CntSat  = '1;
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [3:0]       r_state;
  logic [3:0]       w_state_d;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic [CNT_W-1:0] w_tmo_cnt_d;
  logic [CNT_W-1:0] w_tmo_inc;
  logic [CNT_W-1:0] r_rot_cnt;
  logic [CNT_W-1:0] w_rot_cnt_d;
  logic [CNT_W-1:0] w_rot_inc;
  logic [31:0]      r_angle;

  // Counters saturate instead of wrapping.
  assign w_tmo_inc = (r_tmo_cnt == CntSat) ? r_tmo_cnt : r_tmo_cnt + CntOne;
  assign w_rot_inc = (r_rot_cnt == CntSat) ? r_rot_cnt : r_rot_cnt + CntOne;

  always_comb begin
    w_state_d   = r_state;
    w_tmo_cnt_d = r_tmo_cnt;
    w_rot_cnt_d = r_rot_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_req) w_state_d = StInit;
      end
      StInit: begin
        w_rot_cnt_d = '0;
        w_state_d   = StLstart;
      end
      StLstart: begin
        w_tmo_cnt_d = '0;
        w_state_d   = StLwait;
      end
      StLwait: begin
        if (i_dp_loop_done) begin
          w_state_d = StCheck;
        end else begin
          w_tmo_cnt_d = w_tmo_inc;
          if (w_tmo_inc >= TmoLast) w_state_d = StErr;
        end
      end
      StCheck: begin
        w_state_d = i_dp_angle_gt ? StTp : StVerify;
      end
      StTp:   w_state_d = StYupd;
      StYupd: w_state_d = StXupd;
      StXupd: begin
        w_rot_cnt_d = w_rot_inc;
        w_state_d   = StVerify;
      end
      StVerify: w_state_d = StSettle;
      StSettle: begin
        // Always go back through LSTART so the divider recomputes K every pass.
        if (i_dp_done)                w_state_d = StOut;
        else if (r_rot_cnt == RotMax) w_state_d = StErr;
        else                          w_state_d = StLstart;
      end
      StOut, StErr: begin
        if (i_res_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_tmo_cnt <= '0;
      r_rot_cnt <= '0;
      r_angle   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_tmo_cnt <= w_tmo_cnt_d;
      r_rot_cnt <= w_rot_cnt_d;
      if (r_state == StIdle && i_req) r_angle <= i_req_angle;
    end
  end

  // Every output is a pure decode of the state register.
  always_comb begin
    o_busy          = (r_state != StIdle);
    o_res_valid     = 1'b0;
    o_res_error     = 1'b0;
    o_dp_start      = 1'b0;
    o_dp_start_loop = 1'b0;
    o_dp_tp_we      = 1'b0;
    o_dp_y_we       = 1'b0;
    o_dp_x_we       = 1'b0;
    o_dp_angle_we   = 1'b0;
    o_dp_verify     = 1'b0;
    o_dp_mul_sel    = 1'b0;
    o_dp_add_sel    = 1'b0;
    o_dp_add_sub    = 1'b0;
    unique case (r_state)
      StInit:   o_dp_start      = 1'b1;
      StLstart: o_dp_start_loop = 1'b1;
      StTp: begin
        o_dp_tp_we   = 1'b1;
        o_dp_add_sel = 1'b1;
        o_dp_add_sub = 1'b1;
      end
      StYupd: begin
        o_dp_y_we    = 1'b1;
        o_dp_mul_sel = 1'b1;
      end
      StXupd: begin
        o_dp_x_we     = 1'b1;
        o_dp_angle_we = 1'b1;
      end
      StVerify: o_dp_verify = 1'b1;
      StOut:    o_res_valid = 1'b1;
      StErr: begin
        o_res_valid = 1'b1;
        o_res_error = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_dp_angle = r_angle;

endmodule

// File: tb/tb_tan_cordic_ctrl.sv
// Bench for tan_cordic_ctrl: datapath stub with programmable loop latency, gt pattern
// and done-after-N-verifies, driven by a vector table plus handshake/reset sequences.
module tb_tan_cordic_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] req_angle;
  logic        busy, res_valid, res_ready, res_error;
  logic [31:0] dp_angle;
  logic        dp_start, dp_start_loop, dp_tp_we, dp_y_we, dp_x_we, dp_angle_we, dp_verify;
  logic        dp_mul_sel, dp_add_sel, dp_add_sub;
  logic        dp_loop_done, dp_angle_gt, dp_done;

  int errors = 0;
  int checks = 0;

  int cfg_l  = 1;
  int cfg_gm = 0;
  int cfg_dn = 1;
  int loop_cnt = 0;
  int pass_cnt = 0;
  int ver_cnt  = 0;

  always #5 clk = ~clk;

  tan_cordic_ctrl #(
    .LOOP_TIMEOUT(16),
    .MAX_ROT     (5),
    .CNT_W       (8)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req          (req),
    .i_req_angle    (req_angle),
    .o_busy         (busy),
    .o_res_valid    (res_valid),
    .i_res_ready    (res_ready),
    .o_res_error    (res_error),
    .o_dp_angle     (dp_angle),
    .o_dp_start     (dp_start),
    .o_dp_start_loop(dp_start_loop),
    .o_dp_tp_we     (dp_tp_we),
    .o_dp_y_we      (dp_y_we),
    .o_dp_x_we      (dp_x_we),
    .o_dp_angle_we  (dp_angle_we),
    .o_dp_verify    (dp_verify),
    .o_dp_mul_sel   (dp_mul_sel),
    .o_dp_add_sel   (dp_add_sel),
    .o_dp_add_sub   (dp_add_sub),
    .i_dp_loop_done (dp_loop_done),
    .i_dp_angle_gt  (dp_angle_gt),
    .i_dp_done      (dp_done)
  );

  // Datapath stub: loop_done L cycles after the start_loop pulse (L=0 means never).
  always @(posedge clk) begin
    if (dp_start) begin
      pass_cnt <= 0;
      ver_cnt  <= 0;
    end
    if (dp_start_loop) begin
      loop_cnt <= 1;
      pass_cnt <= pass_cnt + 1;
    end else if (loop_cnt != 0 && loop_cnt < 1000) begin
      loop_cnt <= loop_cnt + 1;
    end
    if (dp_verify) ver_cnt <= ver_cnt + 1;
  end

  assign dp_loop_done = (cfg_l != 0) && (loop_cnt == cfg_l);
  assign dp_angle_gt  = (cfg_gm == 1) || (cfg_gm == 2 && pass_cnt == 1);
  assign dp_done      = (ver_cnt >= cfg_dn);

  typedef struct {
    logic [31:0] ang;
    int          l;
    int          gm;
    int          dn;
    int          cyc;
    bit          err;
    int          nx;
  } row_t;

  row_t rows[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [44:0] all_outs();
    return {busy, res_valid, res_error, dp_angle, dp_start, dp_start_loop, dp_tp_we, dp_y_we,
            dp_x_we, dp_angle_we, dp_verify, dp_mul_sel, dp_add_sel, dp_add_sub};
  endfunction

  function automatic logic [9:0] strobes();
    return {dp_start, dp_start_loop, dp_tp_we, dp_y_we, dp_x_we, dp_angle_we, dp_verify,
            dp_mul_sel, dp_add_sel, dp_add_sub};
  endfunction

  // Issue one request and run to res_valid; the result is then accepted.
  task automatic run_txn(input logic [31:0] ang, input int l, input int gm, input int dn,
                         output int cyc, output bit err, output int nx, output int nt,
                         output int ny, output int na, output bit ang_ok);
    cfg_l = l; cfg_gm = gm; cfg_dn = dn;
    req = 1'b1; req_angle = ang;
    cyc = 0; nx = 0; nt = 0; ny = 0; na = 0; ang_ok = 1'b1; err = 1'b0;
    while (cyc < 600) begin
      step();
      req = 1'b0;
      req_angle = ~ang;
      cyc++;
      nx += int'(dp_x_we);
      nt += int'(dp_tp_we);
      ny += int'(dp_y_we);
      na += int'(dp_angle_we);
      if (dp_angle !== ang) ang_ok = 1'b0;
      if (res_valid) break;
    end
    err = res_error;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    int  cyc, nx, nt, ny, na, n;
    bit  err, ang_ok, seen;
    logic [31:0] held;

    rows[0] = '{32'h3f000000,  3, 0,  8, 58, 1'b0, 0};
    rows[1] = '{32'h3e800000,  1, 0,  1,  7, 1'b0, 0};
    rows[2] = '{32'hbf800000,  2, 2,  1, 11, 1'b0, 1};
    rows[3] = '{32'h40000000,  3, 2,  2, 19, 1'b0, 1};
    rows[4] = '{32'h3f800000,  1, 1,  5, 42, 1'b0, 5};
    rows[5] = '{32'h41200000,  2, 1, 99, 47, 1'b1, 5};
    rows[6] = '{32'h3dcccccd,  0, 0,  1, 18, 1'b1, 0};
    rows[7] = '{32'hc0490fdb, 15, 0,  1, 21, 1'b0, 0};
    rows[8] = '{32'h3c23d70a, 16, 0,  1, 18, 1'b1, 0};

    rst_n = 1'b0; req = 1'b0; req_angle = 32'h0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(all_outs()), 64'h0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", 64'(busy), 64'h0);

    for (int i = 0; i < 9; i++) begin
      run_txn(rows[i].ang, rows[i].l, rows[i].gm, rows[i].dn, cyc, err, nx, nt, ny, na, ang_ok);
      chk($sformatf("row%0d_latency", i), 64'(cyc), 64'(rows[i].cyc));
      chk($sformatf("row%0d_error", i), 64'(err), 64'(rows[i].err));
      chk($sformatf("row%0d_x_we", i), 64'(nx), 64'(rows[i].nx));
      chk($sformatf("row%0d_tp_we", i), 64'(nt), 64'(rows[i].nx));
      chk($sformatf("row%0d_y_we", i), 64'(ny), 64'(rows[i].nx));
      chk($sformatf("row%0d_angle_we", i), 64'(na), 64'(rows[i].nx));
      chk($sformatf("row%0d_dp_angle", i), 64'(ang_ok), 64'h1);
      chk($sformatf("row%0d_back_idle", i), 64'({busy, res_valid}), 64'h0);
    end

    // Rotation strobe order and selects on consecutive cycles.
    cfg_l = 2; cfg_gm = 2; cfg_dn = 1;
    req = 1'b1; req_angle = 32'h3f490fdb;
    step();
    req = 1'b0;
    n = 0;
    while (!dp_tp_we && n < 30) begin
      step();
      n++;
    end
    chk("rot_tp", 64'(strobes()), 64'b0010000011);
    step();
    chk("rot_yupd", 64'(strobes()), 64'b0001000100);
    step();
    chk("rot_xupd", 64'(strobes()), 64'b0000110000);
    step();
    chk("rot_verify", 64'(strobes()), 64'b0000001000);
    n = 0;
    while (!res_valid && n < 30) begin
      step();
      n++;
    end
    chk("rot_valid", 64'({res_valid, res_error}), 64'b10);

    // Result held while ready is low; req toggling must not restart.
    held = dp_angle;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = i[0] ? 1'b0 : 1'b1;
      req_angle = 32'h40490fdb;
      step();
      if (dp_start) seen = 1'b1;
      chk($sformatf("hold_valid%0d", i), 64'(res_valid), 64'h1);
      chk($sformatf("hold_angle%0d", i), 64'(dp_angle), 64'(held));
    end
    chk("hold_no_init", 64'(seen), 64'h0);
    req = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("hold_release", 64'({busy, res_valid}), 64'h0);
    chk("hold_angle_kept", 64'(dp_angle), 64'(held));

    // Asynchronous reset in the middle of YUPD.
    cfg_l = 1; cfg_gm = 2; cfg_dn = 1;
    req = 1'b1; req_angle = 32'h3e000000;
    step();
    req = 1'b0;
    n = 0;
    while (!dp_y_we && n < 30) begin
      step();
      n++;
    end
    chk("rst_in_yupd", 64'(dp_y_we), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", 64'(all_outs()), 64'h0);
    #10 rst_n = 1'b1;
    step();
    run_txn(32'h3f000000, 3, 0, 8, cyc, err, nx, nt, ny, na, ang_ok);
    chk("post_rst_latency", 64'(cyc), 64'd58);
    chk("post_rst_error", 64'(err), 64'h0);
    chk("post_rst_angle", 64'(ang_ok), 64'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
